// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - CPU fetch, byte loader and instruction memory signals of the boot loader
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_valid;
  logic                  ld_start;
  logic                  ld_valid;
  logic [7:0]            ld_byte;
  logic                  ld_ready;
  logic                  ld_end;
  logic                  ld_done;
  logic                  ld_error;
  logic [ADDR_WIDTH:0]   ld_words;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_addr, ld_start, ld_valid, ld_byte, ld_end, mem_rdata,
    output cpu_rdata, cpu_valid, ld_ready, ld_done, ld_error, ld_words,
           mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_addr, ld_start, ld_valid, ld_byte, ld_end, mem_rdata,
    input  cpu_rdata, cpu_valid, ld_ready, ld_done, ld_error, ld_words,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - instruction memory port arbiter between CPU fetch and byte-stream boot loader
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(BYTES) + 1;
  localparam logic [CNT_W-1:0] BYTES_C = CNT_W'(BYTES);

  typedef enum logic [1:0] {RUN, LOAD, WRITE, DONE} state_t;

  state_t                state, state_d;
  logic [CNT_W-1:0]      byte_cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] buffer;
  logic [ADDR_WIDTH:0]   ld_words;
  logic                  ld_error;
  logic                  pend_end;
  logic                  full;
  logic                  restart;
  logic                  ld_ready, cpu_valid, mem_we, ld_done;
  logic [ADDR_WIDTH-1:0] mem_addr;

  // Memory is full once the word count reaches 2^ADDR_WIDTH (top bit set).
  assign full    = ld_words[ADDR_WIDTH];
  assign cnt_inc = byte_cnt + 1'b1;
  assign restart = bus.ld_start && (state == RUN || state == LOAD);

  always_comb begin
    state_d   = state;
    ld_ready  = 1'b0;
    cpu_valid = 1'b0;
    mem_we    = 1'b0;
    ld_done   = 1'b0;
    mem_addr  = word_addr;
    case (state)
      RUN: begin
        cpu_valid = 1'b1;
        mem_addr  = bus.cpu_addr;
        if (bus.ld_start) state_d = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (bus.ld_start) begin
          state_d = LOAD;
        end else if (bus.ld_valid && !full) begin
          if (cnt_inc == BYTES_C || bus.ld_end) state_d = WRITE;
        end else if (bus.ld_end) begin
          state_d = (byte_cnt == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        mem_we  = 1'b1;
        state_d = (pend_end || bus.ld_end) ? DONE : LOAD;
      end
      DONE: begin
        ld_done = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      byte_cnt  <= '0;
      word_addr <= '0;
      buffer    <= '0;
      ld_words  <= '0;
      ld_error  <= 1'b0;
      pend_end  <= 1'b0;
    end else begin
      state <= state_d;
      if (restart) begin
        byte_cnt  <= '0;
        word_addr <= '0;
        buffer    <= '0;
        ld_words  <= '0;
        ld_error  <= 1'b0;
        pend_end  <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (bus.ld_valid) begin
              if (full) begin
                ld_error <= 1'b1;
              end else begin
                buffer[8*byte_cnt +: 8] <= bus.ld_byte;
                byte_cnt                <= cnt_inc;
              end
            end
            if (bus.ld_end) pend_end <= 1'b1;
          end
          WRITE: begin
            // Saturate rather than wrap so a full memory never overwrites word 0.
            if (word_addr != '1) word_addr <= word_addr + 1'b1;
            ld_words <= ld_words + 1'b1;
            byte_cnt <= '0;
            buffer   <= '0;
            if (bus.ld_end) pend_end <= 1'b1;
          end
          default: ;
        endcase
        if (state_d == DONE) pend_end <= 1'b0;
      end
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_valid = cpu_valid;
  assign bus.ld_ready  = ld_ready;
  assign bus.ld_done   = ld_done;
  assign bus.ld_error  = ld_error;
  assign bus.ld_words  = ld_words;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = buffer;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader (full-size and 4-word instances)
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  int  qda[$];
  int  qdb[$];

  logic       sel      = 1'b0;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic       ld_end   = 1'b0;
  logic [7:0] ld_byte  = 8'h00;
  logic [9:0] cpu_addr = 10'd0;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [4];

  imem_boot_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus_a();
  imem_boot_loader_if #(.ADDR_WIDTH(2),  .DATA_WIDTH(32)) bus_b();

  assign bus_a.cpu_addr  = cpu_addr;
  assign bus_a.ld_start  = ld_start & ~sel;
  assign bus_a.ld_valid  = ld_valid & ~sel;
  assign bus_a.ld_byte   = ld_byte;
  assign bus_a.ld_end    = ld_end & ~sel;
  assign bus_a.mem_rdata = mem_a[bus_a.mem_addr];

  assign bus_b.cpu_addr  = cpu_addr[1:0];
  assign bus_b.ld_start  = ld_start & sel;
  assign bus_b.ld_valid  = ld_valid & sel;
  assign bus_b.ld_byte   = ld_byte;
  assign bus_b.ld_end    = ld_end & sel;
  assign bus_b.mem_rdata = mem_b[bus_b.mem_addr];

  imem_boot_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  imem_boot_loader #(.ADDR_WIDTH(2),  .DATA_WIDTH(32)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  always @(posedge clk) if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
  always @(posedge clk) if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;

  wire cur_ready = sel ? bus_b.ld_ready  : bus_a.ld_ready;
  wire cur_valid = sel ? bus_b.cpu_valid : bus_a.cpu_valid;
  wire cur_done  = sel ? bus_b.ld_done   : bus_a.ld_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: every memory write and every ld_done pulse must match the queue head.
  always @(negedge clk) begin
    wr_t w;
    if (!rst) begin
      if (bus_a.mem_we) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_write: got addr=%0d data=%h expected no write", bus_a.mem_addr, bus_a.mem_wdata);
        end else begin
          w = qa.pop_front();
          chk("a_wr_addr", 64'(bus_a.mem_addr), 64'(w.addr));
          chk("a_wr_data", 64'(bus_a.mem_wdata), 64'(w.data));
        end
      end
      if (bus_a.ld_done) begin
        if (qda.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_done: got ld_done=1 expected 0");
        end else begin
          chk("a_ld_words", 64'(bus_a.ld_words), 64'(qda.pop_front()));
        end
      end
      if (bus_b.mem_we) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_write: got addr=%0d data=%h expected no write", bus_b.mem_addr, bus_b.mem_wdata);
        end else begin
          w = qb.pop_front();
          chk("b_wr_addr", 64'(bus_b.mem_addr), 64'(w.addr));
          chk("b_wr_data", 64'(bus_b.mem_wdata), 64'(w.data));
        end
      end
      if (bus_b.ld_done) begin
        if (qdb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_done: got ld_done=1 expected 0");
        end else begin
          chk("b_ld_words", 64'(bus_b.ld_words), 64'(qdb.pop_front()));
        end
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    int n = 0;
    @(negedge clk);
    while (!cur_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: got ld_ready=0 expected 1");
    end
    chk("cpu_valid_in_session", 64'(cur_valid), 64'd0);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_end   = e;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_end   = 1'b0;
  endtask

  task automatic send_end();
    @(negedge clk);
    ld_end = 1'b1;
    @(posedge clk);
    #1;
    ld_end = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!cur_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cur_done) begin
      total++; bad++;
      $display("FAIL done_timeout: got ld_done=0 expected 1");
    end
    @(posedge clk);
    #1;
    chk("cpu_valid_after_done", 64'(cur_valid), 64'd1);
  endtask

  initial begin
    logic [7:0] t2 [8];
    t2 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    mem_a[5] = 32'h0000_0013;

    repeat (2) @(negedge clk);
    chk("rst_cpu_valid", 64'(bus_a.cpu_valid), 64'd1);
    chk("rst_mem_we",    64'(bus_a.mem_we),    64'd0);
    chk("rst_ld_done",   64'(bus_a.ld_done),   64'd0);
    chk("rst_ld_words",  64'(bus_a.ld_words),  64'd0);
    chk("rst_ld_error",  64'(bus_a.ld_error),  64'd0);
    chk("rst_ld_ready",  64'(bus_a.ld_ready),  64'd0);
    rst = 1'b0;

    // T1: combinational fetch passthrough
    cpu_addr = 10'd5;
    @(negedge clk);
    chk("t1_cpu_valid", 64'(bus_a.cpu_valid), 64'd1);
    chk("t1_cpu_rdata", 64'(bus_a.cpu_rdata), 64'h0000_0013);
    chk("t1_mem_addr",  64'(bus_a.mem_addr),  64'd5);

    // T2: two full words, ld_end as a separate pulse
    qa.push_back('{0, 32'h0000_0013});
    qa.push_back('{1, 32'h0010_0093});
    qda.push_back(2);
    do_start();
    for (int i = 0; i < 8; i++) send(t2[i], 1'b0);
    send_end();
    wait_done();
    chk("t2_ld_words", 64'(bus_a.ld_words), 64'd2);
    chk("t2_ld_error", 64'(bus_a.ld_error), 64'd0);

    // T3: partial trailing word padded with zeros
    qa.push_back('{0, 32'h0403_0201});
    qa.push_back('{1, 32'h0000_0605});
    qda.push_back(2);
    do_start();
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    send_end();
    wait_done();
    chk("t3_ld_words", 64'(bus_a.ld_words), 64'd2);

    // T4: ld_end with the last byte of a word
    qa.push_back('{0, 32'hDDCC_BBAA});
    qda.push_back(1);
    do_start();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b1);
    wait_done();
    chk("t4_ld_words", 64'(bus_a.ld_words), 64'd1);

    // T5: 4-word memory, five words sent
    sel = 1'b1;
    for (int k = 0; k < 4; k++)
      qb.push_back('{k, {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}});
    qdb.push_back(4);
    do_start();
    for (int i = 1; i <= 20; i++) send(8'(i), (i == 20));
    wait_done();
    chk("t5_ld_error", 64'(bus_b.ld_error), 64'd1);
    chk("t5_ld_words", 64'(bus_b.ld_words), 64'd4);
    chk("t5_mem0_kept", 64'(mem_b[0]), 64'h0403_0201);
    sel = 1'b0;

    // T6: asynchronous reset in the middle of a session
    do_start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_cpu_valid", 64'(bus_a.cpu_valid), 64'd1);
    chk("t6_mem_we",    64'(bus_a.mem_we),    64'd0);
    chk("t6_ld_error",  64'(bus_a.ld_error),  64'd0);
    chk("t6_ld_words",  64'(bus_a.ld_words),  64'd0);
    chk("t6_b_error",   64'(bus_b.ld_error),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_run_after", 64'(bus_a.cpu_valid), 64'd1);

    chk("qa_empty",  64'(qa.size()),  64'd0);
    chk("qb_empty",  64'(qb.size()),  64'd0);
    chk("qda_empty", 64'(qda.size()), 64'd0);
    chk("qdb_empty", 64'(qdb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
